// File: rtl/mem_pkg.sv
// Shared types and helpers for the byte-enabled data memory and its init engine.
package mem_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Byte-offset width: address bits that must be zero for an aligned word access.
  function automatic int off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage data memory bus: pipeline (master) to memory (slave).
interface dmem_if #(
  parameter int DATA_W = 32
);
  logic [31:0]         addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] be;
  logic                MemWrite;
  logic                MemRead;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                ready;
  logic                misalign;

  modport master (
    output addr, wdata, be, MemWrite, MemRead,
    input  rdata, rvalid, ready, misalign
  );

  modport slave (
    input  addr, wdata, be, MemWrite, MemRead,
    output rdata, rvalid, ready, misalign
  );
endinterface

// File: rtl/dmem_init_ctrl.sv
// Reset-initialisation engine: fills one word per cycle, then holds RUN until reset.
module dmem_init_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int INIT_MODE = 1,
  parameter int AW        = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_we,
  output logic [AW-1:0]     init_addr,
  output logic [DATA_W-1:0] init_data,
  output logic              ready
);

  state_t        state, state_nx;
  logic [AW-1:0] cnt, cnt_nx;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    init_we  = 1'b0;
    ready    = 1'b0;
    unique case (state)
      ST_INIT: begin
        init_we = 1'b1;
        cnt_nx  = cnt + 1'b1;
        if (cnt == AW'(DEPTH - 1)) state_nx = ST_RUN;
      end
      ST_RUN: ready = 1'b1;
      default: state_nx = ST_INIT;
    endcase
  end

  assign init_addr = cnt;
  assign init_data = (INIT_MODE != 0) ? DATA_W'(cnt) : '0;

endmodule

// File: rtl/dmem_bytewise.sv
// Byte-enabled data memory with registered write-first read, misalignment flag
// and a sequential reset fill gating the pipeline through ready.
module dmem_bytewise
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int INIT_MODE = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int AW = addr_w(DEPTH);
  localparam int OW = off_w(DATA_W);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [AW-1:0]     init_addr;
  logic [DATA_W-1:0] init_data;
  logic              ready;

  logic [AW-1:0]     idx;
  logic              misaligned;
  logic              accept, rd_ok, wr_ok, bad;
  logic [DATA_W-1:0] old_word, merged;
  logic              unused_addr_bits;

  dmem_init_ctrl #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INIT_MODE(INIT_MODE),
    .AW       (AW)
  ) u_init (
    .clk      (clk),
    .rst      (rst),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data),
    .ready    (ready)
  );

  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  assign idx              = bus.addr[OW +: AW];
  assign misaligned       = |bus.addr[OW-1:0];
  assign unused_addr_bits = ^bus.addr[31:OW+AW];

  assign accept = ready && !rst;
  assign rd_ok  = accept && bus.MemRead  && !misaligned;
  assign wr_ok  = accept && bus.MemWrite && !misaligned;
  assign bad    = accept && (bus.MemRead || bus.MemWrite) && misaligned;

  // The merged word doubles as the write-first read value for the same address.
  always_comb begin
    old_word = mem[idx];
    merged   = old_word;
    for (int k = 0; k < NB; k++) begin
      merged[8*k +: 8] = merge_byte(old_word[8*k +: 8], bus.wdata[8*k +: 8],
                                    bus.be[k] && bus.MemWrite);
    end
  end

  // NOTE: the storage array has no reset; the init engine fills it after reset instead.
  always_ff @(posedge clk) begin
    if (init_we && !rst)
      mem[init_addr] <= init_data;
    else if (wr_ok)
      mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rdata    <= '0;
      bus.rvalid   <= 1'b0;
      bus.misalign <= 1'b0;
    end else begin
      bus.rvalid   <= rd_ok;
      bus.misalign <= bad;
      if (rd_ok) bus.rdata <= merged;
    end
  end

  assign bus.ready = ready;

endmodule

// File: tb/tb_dmem_bytewise.sv
// Directed bench for dmem_bytewise: 32x32 fill-pattern instance and 64x16 zero-fill instance.
module tb_dmem_bytewise;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   passed = 0;
  int   total  = 0;
  int   n;

  dmem_if #(.DATA_W(32)) a_if ();
  dmem_if #(.DATA_W(64)) b_if ();

  dmem_bytewise #(.DATA_W(32), .DEPTH(32), .INIT_MODE(1)) u_a (
    .clk(clk), .rst(rst_a), .bus(a_if.slave)
  );

  dmem_bytewise #(.DATA_W(64), .DEPTH(16), .INIT_MODE(0)) u_b (
    .clk(clk), .rst(rst_b), .bus(b_if.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    a_if.MemRead  = rd;
    a_if.MemWrite = wr;
    a_if.addr     = addr;
    a_if.wdata    = wdata;
    a_if.be       = be;
  endtask

  task automatic drive_b(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be);
    b_if.MemRead  = rd;
    b_if.MemWrite = wr;
    b_if.addr     = addr;
    b_if.wdata    = wdata;
    b_if.be       = be;
  endtask

  // Counts cycles until ready rises, bounded at 100.
  task automatic wait_ready(input bit use_b, output int cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      cycles++;
      if (use_b ? b_if.ready : a_if.ready) break;
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive_b(1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
    step();
    rst_a = 1'b0;

    check("a_reset_ready",    64'(a_if.ready),    64'd0);
    check("a_reset_rdata",    64'(a_if.rdata),    64'd0);
    check("a_reset_rvalid",   64'(a_if.rvalid),   64'd0);
    check("a_reset_misalign", 64'(a_if.misalign), 64'd0);

    wait_ready(1'b0, n);
    check("a_init_cycles", 64'(n), 64'd32);

    drive_a(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("a_read14_rdata",  64'(a_if.rdata),  64'h5);
    check("a_read14_rvalid", 64'(a_if.rvalid), 64'd1);
    step();
    check("a_idle_rvalid", 64'(a_if.rvalid), 64'd0);
    check("a_idle_rdata",  64'(a_if.rdata),  64'h5);

    drive_a(1'b0, 1'b1, 32'h08, 32'hAABBCCDD, 4'b0101);
    step();
    check("a_write_no_rvalid", 64'(a_if.rvalid), 64'd0);
    drive_a(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
    step();
    check("a_be_merge", 64'(a_if.rdata), 64'h00BB00DD);

    drive_a(1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF);
    step();
    check("a_wfirst_full", 64'(a_if.rdata), 64'h12345678);
    drive_a(1'b1, 1'b0, 32'h90, 32'h0, 4'h0);
    step();
    check("a_wrap_read", 64'(a_if.rdata), 64'h12345678);

    drive_a(1'b1, 1'b1, 32'h0C, 32'h0000AB00, 4'b0010);
    step();
    check("a_wfirst_partial", 64'(a_if.rdata), 64'h0000AB03);

    drive_a(1'b0, 1'b1, 32'h04, 32'hFFFFFFFF, 4'h0);
    step();
    drive_a(1'b1, 1'b0, 32'h04, 32'h0, 4'h0);
    step();
    check("a_be_zero_noop", 64'(a_if.rdata), 64'h1);

    drive_a(1'b1, 1'b0, 32'h0A, 32'h0, 4'h0);
    step();
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("a_misrd_flag",   64'(a_if.misalign), 64'd1);
    check("a_misrd_rvalid", 64'(a_if.rvalid),   64'd0);
    check("a_misrd_rdata",  64'(a_if.rdata),    64'h1);
    step();
    check("a_mis_pulse_end", 64'(a_if.misalign), 64'd0);

    drive_a(1'b0, 1'b1, 32'h0B, 32'hFFFFFFFF, 4'hF);
    step();
    check("a_miswr_flag", 64'(a_if.misalign), 64'd1);
    drive_a(1'b1, 1'b0, 32'h08, 32'h0, 4'h0);
    step();
    check("a_miswr_word2", 64'(a_if.rdata), 64'h00BB00DD);

    // Reset with a read in the same cycle: the read must vanish.
    drive_a(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    check("a_rst_run_rvalid", 64'(a_if.rvalid), 64'd0);
    check("a_rst_run_rdata",  64'(a_if.rdata),  64'd0);
    check("a_rst_run_ready",  64'(a_if.ready),  64'd0);

    drive_a(1'b1, 1'b1, 32'h01, 32'hFFFFFFFF, 4'hF);
    for (int i = 0; i < 10; i++) begin
      step();
      check("a_init_req_rvalid",   64'(a_if.rvalid),   64'd0);
      check("a_init_req_misalign", 64'(a_if.misalign), 64'd0);
    end

    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    drive_a(1'b1, 1'b1, 32'h00, 32'hFFFFFFFF, 4'hF);
    wait_ready(1'b0, n);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check("a_restart_cycles", 64'(n), 64'd32);
    check("a_restart_rvalid", 64'(a_if.rvalid), 64'd0);

    for (int i = 0; i < 32; i++) begin
      drive_a(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0);
      step();
      check("a_fill_word", 64'(a_if.rdata), 64'(i));
    end
    drive_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    rst_b = 1'b0;
    wait_ready(1'b1, n);
    check("b_init_cycles", 64'(n), 64'd16);

    for (int i = 0; i < 16; i++) begin
      drive_b(1'b1, 1'b0, 32'(i * 8), 64'h0, 8'h00);
      step();
      check("b_zero_word", b_if.rdata, 64'h0);
    end

    drive_b(1'b0, 1'b1, 32'h18, 64'hFF00000000000000, 8'h80);
    step();
    drive_b(1'b1, 1'b0, 32'h18, 64'h0, 8'h00);
    step();
    check("b_top_byte",        b_if.rdata,          64'hFF00000000000000);
    check("b_top_byte_rvalid", 64'(b_if.rvalid),    64'd1);
    drive_b(1'b1, 1'b0, 32'h1C, 64'h0, 8'h00);
    step();
    drive_b(1'b0, 1'b0, 32'h0, 64'h0, 8'h00);
    check("b_mis_flag",   64'(b_if.misalign), 64'd1);
    check("b_mis_rvalid", 64'(b_if.rvalid),   64'd0);
    check("b_mis_rdata",  b_if.rdata,         64'hFF00000000000000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
